// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the FIR coefficient loader.
package fir_pkg;

  localparam int COEF_W_DEFAULT = 25;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SHIFT,
    DONE,
    ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_WR_BUSY = 2'd2
  } err_t;

endpackage

// File: rtl/coef_ram.sv
// rtl/coef_ram.sv - simple dual-port coefficient buffer, sync write, registered read, no reset.
module coef_ram
  import fir_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = COEF_W_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - shifts a buffered tap set into the filter's coefficient chain,
// leading zero padding first, then h[ntaps-1] down to h[0].
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int MAX_TAPS = 64,
  parameter int COEF_W   = COEF_W_DEFAULT,
  parameter int AW       = $clog2(MAX_TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [AW:0]       ntaps,
  input  logic              start,
  input  logic [31:0]       fir_len,
  output logic [COEF_W-1:0] cfg_din,
  output logic              cfg_ce,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  loader_state_t     state, state_nxt;
  logic [AW:0]       ntaps_r;
  logic [31:0]       len_r, pad_r, cnt, ntaps_ext;
  logic [AW-1:0]     idx;
  logic              ce_q, zero_q, len_bad, issue, issue_zero;
  logic [COEF_W-1:0] rd_data;

  assign ntaps_ext  = {{(31-AW){1'b0}}, ntaps_r};
  assign len_bad    = ntaps_ext > len_r;
  assign issue      = (state == SHIFT) && (cnt != len_r);
  assign issue_zero = cnt < pad_r;

  coef_ram #(.DEPTH(MAX_TAPS), .W(COEF_W), .AW(AW)) u_ram (
    .clk     (clk),
    .we      (wr_en && !busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // SHIFT lingers one cycle past the last issue so done lands after the final registered cfg_ce.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = len_bad ? ERR : ((len_r == 32'd0) ? DONE : SHIFT);
      SHIFT:   if (!issue) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE) || (state == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ntaps_r <= '0;
      len_r   <= '0;
      pad_r   <= '0;
      cnt     <= '0;
      idx     <= '0;
      ce_q    <= 1'b0;
      zero_q  <= 1'b0;
      err     <= ERR_NONE;
    end else begin
      ce_q   <= issue;
      zero_q <= issue && issue_zero;
      case (state)
        IDLE: if (start) begin
          ntaps_r <= ntaps;
          len_r   <= fir_len;
        end
        CHECK: begin
          pad_r <= len_r - ntaps_ext;
          idx   <= ntaps_r[AW-1:0] - AW'(1);
          cnt   <= '0;
        end
        SHIFT: if (issue) begin
          cnt <= cnt + 32'd1;
          if (!issue_zero) idx <= idx - AW'(1);
        end
        default: ;
      endcase
      if (state == IDLE && start)              err <= ERR_NONE;
      else if (state == CHECK && len_bad)      err <= ERR_LEN;
      else if (wr_en && busy && err != ERR_LEN) err <= ERR_WR_BUSY;
    end
  end

  // Read data arrives one cycle after the issue; pad slots are forced to zero here.
  assign cfg_din = (ce_q && !zero_q) ? rd_data : '0;
  assign cfg_ce  = ce_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb/tb_fir_coef_loader.sv - self-checking bench for fir_coef_loader against a queue-based tap model.
module tb_fir_coef_loader;

  logic        clk = 1'b0;
  logic        reset, wr_en, start;
  logic [5:0]  wr_addr;
  logic [24:0] wr_data;
  logic [6:0]  ntaps;
  logic [31:0] fir_len;
  logic [24:0] cfg_din;
  logic        cfg_ce, busy, done;
  logic [1:0]  err;

  fir_coef_loader dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ntaps(ntaps), .start(start), .fir_len(fir_len), .cfg_din(cfg_din), .cfg_ce(cfg_ce),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [24:0] model_buf [64];
  logic [24:0] exp_q [$];
  logic [24:0] obs_q [$];
  int first_ce, last_ce, ce_cnt, done_n, done_cnt, busy_gap, din_leak;
  logic busy_after;
  logic [1:0] err_end;

  task automatic wr_word(input int a, input logic [24:0] d);
    wr_en = 1'b1; wr_addr = a[5:0]; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model_buf[a] = d;
  endtask

  // Chain contents after a load: pad zeros first, then h[nt-1] .. h[0].
  task automatic build_exp(input int nt, input int len);
    exp_q.delete();
    for (int i = 0; i < len - nt; i++) exp_q.push_back('0);
    for (int k = nt - 1; k >= 0; k--) exp_q.push_back(model_buf[k]);
  endtask

  function automatic int words_diff();
    int d = 0;
    if (obs_q.size() != exp_q.size()) return 1000;
    foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  // Starts a load and records what the DUT does, cycle n = n cycles after the sampling edge.
  task automatic run_load(input int nt, input int len, input int wr_at, input logic [24:0] wr_val);
    obs_q.delete();
    first_ce = -1; last_ce = -1; ce_cnt = 0; done_n = -1; done_cnt = 0;
    busy_gap = 0; din_leak = 0; busy_after = 1'b1; err_end = 2'b11;
    ntaps = nt[6:0]; fir_len = len; start = 1'b1;
    for (int n = 1; n <= len + 12; n++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (cfg_ce) begin
        if (first_ce < 0) first_ce = n;
        last_ce = n; ce_cnt++; obs_q.push_back(cfg_din);
      end else if (cfg_din !== '0) din_leak++;
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (done_n < 0 || n == done_n) begin
        if (!busy) busy_gap++;
      end else begin
        busy_after = busy; err_end = err;
        break;
      end
      if (n == wr_at) begin
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = wr_val;
        start = 1'b1; ntaps = 7'd1; fir_len = 32'd5;
      end
    end
    wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cfg_ce !== 1'b0)  begin errors++; $display("FAIL reset_cfg_ce got %0b want 0", cfg_ce); end
    checks++; if (cfg_din !== '0)   begin errors++; $display("FAIL reset_cfg_din got %0h want 0", cfg_din); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (err !== 2'd0)     begin errors++; $display("FAIL reset_err got %0d want 0", err); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({cfg_ce, busy, done} !== 3'b000) begin errors++; $display("FAIL post_reset_idle got %b want 000", {cfg_ce, busy, done}); end
  endtask

  task automatic test_exact();
    for (int k = 0; k < 21; k++) wr_word(k, 25'(k + 1));
    build_exp(21, 21);
    run_load(21, 21, 0, '0);
    checks++; if (ce_cnt != 21)     begin errors++; $display("FAIL exact_ce_count got %0d want 21", ce_cnt); end
    checks++; if (first_ce != 3)    begin errors++; $display("FAIL exact_first_ce got %0d want 3", first_ce); end
    checks++; if (last_ce != 23)    begin errors++; $display("FAIL exact_last_ce got %0d want 23", last_ce); end
    checks++; if (done_n != 24)     begin errors++; $display("FAIL exact_done got %0d want 24", done_n); end
    checks++; if (words_diff() != 0) begin errors++; $display("FAIL exact_words diff %0d want 0", words_diff()); end
    checks++; if (busy_gap != 0 || busy_after !== 1'b0) begin errors++; $display("FAIL exact_busy gap %0d after %0b want 0 0", busy_gap, busy_after); end
    checks++; if (err_end !== 2'd0 || din_leak != 0) begin errors++; $display("FAIL exact_err_leak err %0d leak %0d want 0 0", err_end, din_leak); end
  endtask

  task automatic test_padding();
    wr_word(0, 25'd5); wr_word(1, 25'd6); wr_word(2, 25'd7);
    build_exp(3, 21);
    run_load(3, 21, 0, '0);
    checks++; if (ce_cnt != 21)      begin errors++; $display("FAIL pad_ce_count got %0d want 21", ce_cnt); end
    checks++; if (words_diff() != 0) begin errors++; $display("FAIL pad_words diff %0d want 0", words_diff()); end
    checks++; if (obs_q.size() == 21 && obs_q[18] !== 25'd7) begin errors++; $display("FAIL pad_first_nonzero got %0d want 7", obs_q[18]); end
  endtask

  task automatic test_clear();
    build_exp(0, 21);
    run_load(0, 21, 0, '0);
    checks++; if (ce_cnt != 21)      begin errors++; $display("FAIL clear_ce_count got %0d want 21", ce_cnt); end
    checks++; if (words_diff() != 0) begin errors++; $display("FAIL clear_words diff %0d want 0", words_diff()); end
    checks++; if (err_end !== 2'd0)  begin errors++; $display("FAIL clear_err got %0d want 0", err_end); end
  endtask

  task automatic test_zero_len();
    run_load(0, 0, 0, '0);
    checks++; if (ce_cnt != 0)   begin errors++; $display("FAIL zlen_ce_count got %0d want 0", ce_cnt); end
    checks++; if (done_n != 2)   begin errors++; $display("FAIL zlen_done got %0d want 2", done_n); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zlen_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_len_err();
    run_load(22, 21, 0, '0);
    checks++; if (ce_cnt != 0)     begin errors++; $display("FAIL lerr_ce_count got %0d want 0", ce_cnt); end
    checks++; if (done_n != 2)     begin errors++; $display("FAIL lerr_done got %0d want 2", done_n); end
    checks++; if (err_end !== 2'd1) begin errors++; $display("FAIL lerr_err got %0d want 1", err_end); end
    build_exp(21, 21);
    run_load(21, 21, 0, '0);
    checks++; if (err_end !== 2'd0) begin errors++; $display("FAIL lerr_clear got %0d want 0", err_end); end
    checks++; if (words_diff() != 0) begin errors++; $display("FAIL lerr_reload_words diff %0d want 0", words_diff()); end
  endtask

  task automatic test_busy();
    build_exp(21, 21);
    run_load(21, 21, 8, 25'h1ABCDE);
    checks++; if (ce_cnt != 21 || done_n != 24) begin errors++; $display("FAIL busy_load got ce %0d done %0d want 21 24", ce_cnt, done_n); end
    checks++; if (words_diff() != 0) begin errors++; $display("FAIL busy_words diff %0d want 0", words_diff()); end
    checks++; if (err_end !== 2'd2)  begin errors++; $display("FAIL busy_err got %0d want 2", err_end); end
    run_load(21, 21, 0, '0);
    checks++; if (words_diff() != 0) begin errors++; $display("FAIL busy_next_words diff %0d want 0", words_diff()); end
    checks++; if (obs_q.size() == 21 && obs_q[20] !== model_buf[0]) begin errors++; $display("FAIL busy_buf0 got %0h want %0h", obs_q[20], model_buf[0]); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    ntaps = 7'd21; fir_len = 32'd21; start = 1'b1;
    for (int n = 0; n < 40 && seen < 10; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (cfg_ce) seen++;
    end
    checks++; if (seen != 10) begin errors++; $display("FAIL rmid_reach got %0d want 10", seen); end
    #1 reset = 1'b0;
    #1;
    checks++; if ({cfg_ce, busy, done, err} !== 5'b0 || cfg_din !== '0) begin errors++; $display("FAIL rmid_outputs got ce %0b busy %0b done %0b err %0d din %0h want 0", cfg_ce, busy, done, err, cfg_din); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    build_exp(21, 21);
    run_load(21, 21, 0, '0);
    checks++; if (ce_cnt != 21 || done_n != 24) begin errors++; $display("FAIL rmid_reload got ce %0d done %0d want 21 24", ce_cnt, done_n); end
    checks++; if (words_diff() != 0) begin errors++; $display("FAIL rmid_words diff %0d want 0", words_diff()); end
  endtask

  task automatic test_random();
    int nt, len, exp_done, exp_ce, exp_err;
    for (int a = 0; a < 64; a++) wr_word(a, 25'($urandom()));
    for (int it = 0; it < 10; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 8)); w++) wr_word(int'($urandom_range(0, 63)), 25'($urandom()));
      len = int'($urandom_range(0, 40));
      nt  = (it % 3 == 0) ? int'($urandom_range(0, 64)) : int'($urandom_range(0, len));
      exp_err  = (nt > len) ? 1 : 0;
      exp_ce   = exp_err ? 0 : len;
      exp_done = (exp_err || len == 0) ? 2 : len + 3;
      if (exp_err) exp_q.delete(); else build_exp(nt, len);
      run_load(nt, len, 0, '0);
      checks++; if (ce_cnt != exp_ce)     begin errors++; $display("FAIL rnd%0d_ce_count got %0d want %0d", it, ce_cnt, exp_ce); end
      checks++; if (done_n != exp_done)   begin errors++; $display("FAIL rnd%0d_done got %0d want %0d", it, done_n, exp_done); end
      checks++; if (err_end !== 2'(exp_err)) begin errors++; $display("FAIL rnd%0d_err got %0d want %0d", it, err_end, exp_err); end
      checks++; if (words_diff() != 0)    begin errors++; $display("FAIL rnd%0d_words diff %0d want 0", it, words_diff()); end
      checks++; if (ce_cnt > 0 && (first_ce != 3 || last_ce - first_ce + 1 != ce_cnt)) begin errors++; $display("FAIL rnd%0d_ce_window got %0d..%0d want 3..%0d", it, first_ce, last_ce, exp_ce + 2); end
      checks++; if (busy_gap != 0 || done_cnt != 1 || din_leak != 0) begin errors++; $display("FAIL rnd%0d_ctrl gap %0d pulses %0d leak %0d want 0 1 0", it, busy_gap, done_cnt, din_leak); end
    end
  endtask

  initial begin
    wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_data = '0; ntaps = '0; fir_len = '0;
    test_reset();
    test_exact();
    test_padding();
    test_clear();
    test_zero_len();
    test_len_err();
    test_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
